// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder for core STR/LDR requests
// One request in flight; LATENCY wait states, then a one-cycle registered response.
module data_mem_responder #(
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 1,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [AW-1:0]   addr_q;
  logic            we_q, err_q;
  logic [31:0]     mem [DEPTH];

  logic            accept, in_range;
  logic [AW-1:0]   cur_addr;
  logic            cur_we, cur_err;

  // Full 32-bit unsigned compare, so wrapped negative offsets are out of range.
  assign accept   = req_valid && (state == IDLE);
  assign in_range = req_addr < 32'(DEPTH);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // With zero wait states the response is formed on the acceptance edge itself,
  // so the transaction fields come straight from the request in IDLE.
  always_comb begin
    cur_addr = addr_q;
    cur_we   = we_q;
    cur_err  = err_q;
    if (state == IDLE) begin
      cur_addr = req_addr[AW-1:0];
      cur_we   = req_we;
      cur_err  = !in_range;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        addr_q <= req_addr[AW-1:0];
        we_q   <= req_we;
        err_q  <= !in_range;
      end
      rsp_valid <= (state_d == RESP);
      rsp_err   <= (state_d == RESP) && cur_err;
      rsp_rdata <= ((state_d == RESP) && !cur_we && !cur_err) ? mem[cur_addr] : 32'd0;
    end
  end

  generate
    if (INIT_ZERO) begin : g_mem_clr
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (accept && req_we && in_range) begin
          mem[cur_addr] <= req_wdata;
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (accept && req_we && in_range) mem[cur_addr] <= req_wdata;
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
// Four instances with LATENCY 0/1/3/15; instance 1 carries the main sequence.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_we    [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic        rsp_valid [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];
  logic        busy      [4];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      data_mem_responder #(
        .DEPTH(64),
        .LATENCY((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15),
        .INIT_ZERO(1'b1)
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid[g]),
        .req_ready(req_ready[g]),
        .req_we   (req_we[g]),
        .req_addr (req_addr[g]),
        .req_wdata(req_wdata[g]),
        .rsp_valid(rsp_valid[g]),
        .rsp_rdata(rsp_rdata[g]),
        .rsp_err  (rsp_err[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

  function automatic int lat_of(int d);
    case (d)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [31:0] r, logic e);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(int d, string tag);
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed unexpected response expected none", tag);
    end else begin
      x = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata[d], x.rdata);
      check({tag, "_err"}, 32'(rsp_err[d]), 32'(x.err));
    end
  endtask

  task automatic do_req(int d, string tag, logic we, logic [31:0] addr, logic [31:0] wdata,
                        logic [31:0] exp_rdata, logic exp_err);
    int  n;
    bit  got;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    push(exp_rdata, exp_err);
    n = 0;
    while (!req_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      tests++;
      fails++;
      $error("FAIL %s_accept: observed no ready expected ready within 100 cycles", tag);
      req_valid[d] = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = 'x;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, "_busy"}, 32'(busy[d]), 32'd1);
      if (rsp_valid[d]) begin
        got = 1'b1;
        check({tag, "_lat"}, 32'(k), 32'(lat_of(d) + 1));
        pop_check(d, tag);
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $error("FAIL %s_rsp: observed no response expected one within 40 cycles", tag);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic sweep(int d);
    int accepts = 0;
    int rsps    = 0;
    int run     = 0;
    bit prev    = 1'b0;
    do_req(d, "sw_store", 1'b1, 32'(d + 1), 32'h100 + 32'(d), 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) push(32'h100 + 32'(d), 1'b0);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = 1'b0;
    req_addr[d]  = 32'(d + 1);
    for (int n = 0; n < 300; n++) begin
      if (rsp_valid[d]) begin
        rsps++;
        check("sw_pulse", 32'(prev), 32'd0);
        pop_check(d, "sw_rsp");
      end
      prev = rsp_valid[d];
      if (!req_ready[d]) begin
        run++;
      end else begin
        if (run > 0) check("sw_stall", 32'(run), 32'(lat_of(d) + 1));
        run = 0;
        if (req_valid[d]) accepts++;
      end
      if (accepts == 3 && rsps == 3 && req_ready[d]) break;
      @(posedge clk);
      #1;
      if (accepts == 3) req_valid[d] = 1'b0;
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    check("sw_accepts", 32'(accepts), 32'd3);
    check("sw_rsps", 32'(rsps), 32'd3);
    check("sw_sb_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_addr;
    int          stray;

    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready[1]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_busy", 32'(busy[1]), 32'd0);
    check("rst_rdata", rsp_rdata[1], 32'd0);
    do_req(1, "ld3", 1'b0, 32'd3, 32'd0, 32'd0, 1'b0);

    do_req(1, "st14", 1'b1, 32'd14, 32'd6, 32'd0, 1'b0);
    do_req(1, "st7", 1'b1, 32'd7, 32'd14, 32'd0, 1'b0);
    do_req(1, "st5", 1'b1, 32'd5, 32'd14, 32'd0, 1'b0);
    do_req(1, "ld14", 1'b0, 32'd14, 32'd0, 32'd6, 1'b0);
    do_req(1, "ld7", 1'b0, 32'd7, 32'd0, 32'd14, 1'b0);
    do_req(1, "ld5", 1'b0, 32'd5, 32'd0, 32'd14, 1'b0);

    // 6 + (-7) wraps to all ones; its low bits alias word 63, which must stay clear.
    wrap_addr = 32'd6 + 32'hFFFF_FFF9;
    do_req(1, "st_wrap", 1'b1, wrap_addr, 32'hDEAD_BEEF, 32'd0, 1'b1);
    do_req(1, "ld5_after_wrap", 1'b0, 32'd5, 32'd0, 32'd14, 1'b0);
    do_req(1, "ld14_after_wrap", 1'b0, 32'd14, 32'd0, 32'd6, 1'b0);
    do_req(1, "ld63_after_wrap", 1'b0, 32'd63, 32'd0, 32'd0, 1'b0);

    for (int d = 0; d < 4; d++) sweep(d);

    do_req(2, "st14_l3", 1'b1, 32'd14, 32'h77, 32'd0, 1'b0);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2]  = 32'd14;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    @(posedge clk);
    #2;
    check("mid_busy_before", 32'(busy[2]), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy[2]), 32'd0);
    check("mid_ready", 32'(req_ready[2]), 32'd1);
    check("mid_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid[2]) stray++;
    end
    check("mid_no_rsp", 32'(stray), 32'd0);
    check("mid_idle", 32'(req_ready[2]), 32'd1);
    do_req(1, "ld14_cleared", 1'b0, 32'd14, 32'd0, 32'd0, 1'b0);

    do_req(1, "st63", 1'b1, 32'd63, 32'hA5A5_A5A5, 32'd0, 1'b0);
    do_req(1, "ld63", 1'b0, 32'd63, 32'd0, 32'hA5A5_A5A5, 1'b0);
    do_req(1, "ld64", 1'b0, 32'd64, 32'd0, 32'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
